// File: rtl/fib_stack.sv
// fib_stack: LIFO stack serving the recursive-Fibonacci controller's push/pop strobes.
// Mode (EMPTY/PARTIAL/FULL) is decoded from the stack pointer, which is the only state.
module fib_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} mode_t;
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] IX_ONE  = AW'(1);
  mode_t            w_mode;
  logic [AW:0]      r_sp, w_sp_nxt;
  logic             r_ovf, r_udf, w_ovf_nxt, w_udf_nxt, w_we;
  logic [AW-1:0]    w_top_idx, w_waddr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_comb begin
    w_mode    = r_sp == '0 ? EMPTY : r_sp == SP_FULL ? FULL : PARTIAL;
    w_top_idx = r_sp[AW-1:0] - IX_ONE;
  end
  always_comb begin
    w_sp_nxt  = r_sp;
    w_ovf_nxt = r_ovf;
    w_udf_nxt = r_udf;
    w_we      = 1'b0;
    w_waddr   = r_sp[AW-1:0];
    if (push && pop) begin
      // Simultaneous strobes replace the top; on an empty stack they degrade to a push with underflow.
      w_we = 1'b1;
      if (w_mode == EMPTY) begin
        w_sp_nxt  = SP_ONE;
        w_udf_nxt = 1'b1;
      end else begin
        w_waddr = w_top_idx;
      end
    end else if (push) begin
      w_we      = w_mode != FULL;
      w_sp_nxt  = w_mode != FULL ? r_sp + SP_ONE : r_sp;
      w_ovf_nxt = r_ovf | (w_mode == FULL);
    end else if (pop) begin
      w_sp_nxt  = w_mode != EMPTY ? r_sp - SP_ONE : r_sp;
      w_udf_nxt = r_udf | (w_mode == EMPTY);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      r_ovf <= w_ovf_nxt;
      r_udf <= w_udf_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && !clr && w_we) r_mem[w_waddr] <= din;
  end
  assign top   = w_mode == EMPTY ? '0 : r_mem[w_top_idx];
  assign count = r_sp;
  assign empty = w_mode == EMPTY;
  assign full  = w_mode == FULL;
  assign ovf   = r_ovf;
  assign udf   = r_udf;
endmodule

// File: tb/tb_fib_stack.sv
// tb_fib_stack: scoreboard bench; a behavioural stack model queues the expected
// post-edge state for every driven cycle, compared once the edge has happened.
module tb_fib_stack;
  typedef struct {
    logic [15:0] top;
    logic [4:0]  count;
    logic        empty, full, ovf, udf;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] top;
  logic [4:0]  count;
  logic        empty, full, ovf, udf;
  int          n_cmp = 0, n_err = 0;
  exp_t        sb[$];
  logic [15:0] m_mem [16];
  int          m_sp = 0;
  logic        m_ovf = 1'b0, m_udf = 1'b0;
  fib_stack #(.WIDTH(16), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
    .top(top), .count(count), .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic c, input logic pu, input logic po, input logic [15:0] d);
    exp_t e, a;
    rst = r; clr = c; push = pu; pop = po; din = d;
    if (!r || c) begin
      m_sp = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (pu && po) begin
      if (m_sp == 0) begin m_mem[0] = d; m_sp = 1; m_udf = 1'b1; end
      else m_mem[m_sp-1] = d;
    end else if (pu) begin
      if (m_sp == 16) m_ovf = 1'b1;
      else begin m_mem[m_sp] = d; m_sp++; end
    end else if (po) begin
      if (m_sp == 0) m_udf = 1'b1;
      else m_sp--;
    end
    e.top = m_sp == 0 ? 16'h0 : m_mem[m_sp-1];
    e.count = 5'(m_sp);
    e.empty = m_sp == 0;
    e.full = m_sp == 16;
    e.ovf = m_ovf;
    e.udf = m_udf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a = sb.pop_front();
    chk("top", 32'(top), 32'(a.top));
    chk("count", 32'(count), 32'(a.count));
    chk("empty", 32'(empty), 32'(a.empty));
    chk("full", 32'(full), 32'(a.full));
    chk("ovf", 32'(ovf), 32'(a.ovf));
    chk("udf", 32'(udf), 32'(a.udf));
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 16'h0003);
    drive(1, 0, 1, 0, 16'h0005);
    drive(0, 0, 1, 1, 16'h0009);
    chk("t1_reset_count", 32'(count), 0);
    drive(1, 0, 0, 1, 0);
    chk("t1_udf", 32'(udf), 1);
    drive(1, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) drive(1, 0, 1, 0, 16'(i));
    chk("t2_top", 32'(top), 32'h3);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0);
    chk("t2_empty", 32'(empty), 1);
    for (int i = 0; i < 16; i++) drive(1, 0, 1, 0, 16'(i));
    drive(1, 0, 1, 0, 16'h00AA);
    chk("t3_ovf_top", 32'(top), 32'hF);
    drive(1, 0, 1, 1, 16'h00BB);
    chk("t3_replace_top", 32'(top), 32'hBB);
    chk("t3_ovf_sticky", 32'(ovf), 1);
    drive(1, 1, 1, 0, 16'h0055);
    chk("t6_clr_count", 32'(count), 0);
    chk("t6_clr_ovf", 32'(ovf), 0);
    drive(1, 0, 1, 1, 16'h0007);
    chk("t4_top", 32'(top), 32'h7);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 16'h0011);
    drive(1, 0, 1, 0, 16'h0022);
    drive(1, 0, 1, 1, 16'h0033);
    chk("t5_top", 32'(top), 32'h33);
    drive(1, 0, 0, 1, 0);
    chk("t5_pop_top", 32'(top), 32'h11);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
